factorial_queue: RTL and testbench

FACTORIAL_QUEUE -- requirements
Module: factorial_queue

---
 rtl/factorial_queue.sv | 170 +++++++++++++++++
 tb/tb_factorial_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/factorial_queue.sv
// Memory-mapped factorial engine: operands queue in, N! (2W bits, truncated) queues out.
// A single FSM walks LOAD/MUL/WRITE per operand and raises done when the operand queue drains.
module factorial_queue #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_sel,
  input  logic         s_wr,
  input  logic [7:0]   s_addr,
  input  logic [W-1:0] s_din,
  output logic [W-1:0] s_dout,
  output logic         interrupt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StMul, StWrite, StDone} state_e;

  state_e         state_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   mult_q;
  logic           done_q, overflow_q, push_err_q, intren_q;

  logic [W-1:0]   op_mem_q [DEPTH];
  logic [AW-1:0]  op_rd_q, op_wr_q;
  logic [CW-1:0]  op_cnt_q;
  logic [2*W-1:0] res_mem_q [DEPTH];
  logic [AW-1:0]  res_rd_q, res_wr_q;
  logic [CW-1:0]  res_cnt_q;

  logic wr_en, rd_en, op_start, op_clear, op_push_req, op_full, op_push, op_pop;
  logic res_full, res_push, res_pop, busy;
  logic [3*W-1:0] prod;
  logic [2*W-1:0] res_head;
  logic [W-1:0]   status;

  assign wr_en       = s_sel & s_wr;
  assign rd_en       = s_sel & ~s_wr;
  assign op_start    = wr_en && (s_addr == 8'h00) && s_din[0];
  assign op_clear    = wr_en && (s_addr == 8'h08) && s_din[0];
  assign op_push_req = wr_en && (s_addr == 8'h20);
  assign op_full     = (op_cnt_q == CW'(DEPTH));
  assign op_push     = op_push_req & ~op_full;
  assign op_pop      = (state_q == StLoad) && (op_cnt_q != '0);
  assign res_full    = (res_cnt_q == CW'(DEPTH));
  assign res_push    = (state_q == StWrite) && !res_full;
  assign res_pop     = rd_en && (s_addr == 8'h30) && (res_cnt_q != '0);
  assign busy        = (state_q == StLoad) || (state_q == StMul) || (state_q == StWrite);
  assign interrupt   = done_q & intren_q;
  assign res_head    = (res_cnt_q != '0) ? res_mem_q[res_rd_q] : '0;
  assign prod        = {{W{1'b0}}, acc_q} * {{(2*W){1'b0}}, mult_q};

  always_comb begin
    status             = '0;
    status[0]          = done_q;
    status[1]          = busy;
    status[2]          = overflow_q;
    status[3]          = push_err_q;
    status[8 +: CW]    = op_cnt_q;
    status[16 +: CW]   = res_cnt_q;
  end

  always_comb begin
    s_dout = '0;
    if (rd_en) begin
      case (s_addr)
        8'h10:   s_dout = status;
        8'h18:   s_dout = {{(W-1){1'b0}}, intren_q};
        8'h20:   s_dout = W'(op_cnt_q);
        8'h28:   s_dout = res_head[2*W-1:W];
        8'h30:   s_dout = res_head[W-1:0];
        default: s_dout = '0;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy is tracked by the counters alone.
  always_ff @(posedge clk) begin
    if (op_push)  op_mem_q[op_wr_q]   <= s_din;
    if (res_push) res_mem_q[res_wr_q] <= acc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_rd_q   <= '0;
      op_wr_q   <= '0;
      op_cnt_q  <= '0;
      res_rd_q  <= '0;
      res_wr_q  <= '0;
      res_cnt_q <= '0;
    end else if (op_clear) begin
      op_rd_q   <= '0;
      op_wr_q   <= '0;
      op_cnt_q  <= '0;
      res_rd_q  <= '0;
      res_wr_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (op_push)  op_wr_q  <= op_wr_q + AW'(1);
      if (op_pop)   op_rd_q  <= op_rd_q + AW'(1);
      if (res_push) res_wr_q <= res_wr_q + AW'(1);
      if (res_pop)  res_rd_q <= res_rd_q + AW'(1);
      if (op_push && !op_pop)       op_cnt_q <= op_cnt_q + CW'(1);
      else if (!op_push && op_pop)  op_cnt_q <= op_cnt_q - CW'(1);
      if (res_push && !res_pop)      res_cnt_q <= res_cnt_q + CW'(1);
      else if (!res_push && res_pop) res_cnt_q <= res_cnt_q - CW'(1);
    end
  end

  // INTREN survives OPCLEAR; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      intren_q <= 1'b0;
    end else if (wr_en && (s_addr == 8'h18)) begin
      intren_q <= s_din[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      mult_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      push_err_q <= 1'b0;
    end else if (op_clear) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      mult_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      push_err_q <= 1'b0;
    end else begin
      if (op_push_req && op_full) push_err_q <= 1'b1;
      unique case (state_q)
        StIdle, StDone: begin
          if (op_start) begin
            done_q  <= 1'b0;
            state_q <= (op_cnt_q != '0) ? StLoad : StDone;
          end else if (state_q == StDone) begin
            done_q <= 1'b1;
          end
        end
        StLoad: begin
          mult_q  <= op_mem_q[op_rd_q];
          acc_q   <= {{(2*W-1){1'b0}}, 1'b1};
          state_q <= StMul;
        end
        StMul: begin
          if (mult_q <= W'(1)) begin
            state_q <= StWrite;
          end else begin
            acc_q  <= prod[2*W-1:0];
            mult_q <= mult_q - W'(1);
            if (|prod[3*W-1:2*W]) overflow_q <= 1'b1;
          end
        end
        StWrite: begin
          if (!res_full) state_q <= (op_cnt_q != '0) ? StLoad : StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_queue.sv
// Directed and randomized checks of factorial_queue against a plain-arithmetic factorial model.
module tb_factorial_queue;

  localparam int unsigned W     = 64;
  localparam int unsigned DEPTH = 4;

  localparam logic [7:0] A_START  = 8'h00;
  localparam logic [7:0] A_CLEAR  = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h10;
  localparam logic [7:0] A_INTREN = 8'h18;
  localparam logic [7:0] A_OPER   = 8'h20;
  localparam logic [7:0] A_RESH   = 8'h28;
  localparam logic [7:0] A_RESL   = 8'h30;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_sel = 1'b0;
  logic         s_wr = 1'b0;
  logic [7:0]   s_addr = '0;
  logic [W-1:0] s_din = '0;
  logic [W-1:0] s_dout;
  logic         interrupt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_q [$];
  bit             exp_ov;

  factorial_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Truncated factorial; overflow whenever a discarded product bit is set.
  task automatic model_push(input int n);
    logic [2*W-1:0] acc = 1;
    logic [3*W-1:0] p;
    for (int k = n; k > 1; k--) begin
      p = acc * k;
      if (p[3*W-1:2*W] != 0) exp_ov = 1'b1;
      acc = p[2*W-1:0];
    end
    exp_q.push_back(acc);
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = addr; s_din = data;
    @(posedge clk);
    #1;
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [W-1:0] data);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = addr;
    #1;
    data = s_dout;
    @(posedge clk);
    #1;
    s_sel = 1'b0;
  endtask

  task automatic push_op(input int n);
    bus_write(A_OPER, W'(n));
    model_push(n);
  endtask

  task automatic wait_done(input int budget);
    logic [W-1:0] st;
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      bus_read(A_STATUS, st);
      ok = st[0];
    end
    check("done_wait", {127'd0, ok}, 128'd1);
  endtask

  task automatic drain_results(input string tag);
    logic [W-1:0] hi, lo;
    logic [2*W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus_read(A_RESH, hi);
      bus_read(A_RESL, lo);
      check(tag, {hi, lo}, e);
    end
  endtask

  initial begin
    logic [W-1:0] rd;
    bit int_seen;
    int nops;

    // Reset values
    exp_ov = 1'b0;
    #1;
    check("rst_interrupt", {127'd0, interrupt}, 128'd0);
    check("rst_dout", {64'd0, s_dout}, 128'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    bus_read(A_STATUS, rd);
    check("rst_status", {64'd0, rd}, 128'd0);

    // 5! with interrupt timing
    push_op(5);
    bus_write(A_INTREN, 64'd1);
    bus_write(A_START, 64'd1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 7) check("int_early", {127'd0, interrupt}, 128'd0);
      if (i == 8) check("int_rise", {127'd0, interrupt}, 128'd1);
    end
    bus_read(A_RESH, rd);
    check("fact5_h", {64'd0, rd}, 128'd0);
    bus_read(A_RESL, rd);
    check("fact5_l", {64'd0, rd}, 128'd120);
    void'(exp_q.pop_front());
    bus_read(A_STATUS, rd);
    check("fact5_rescnt", {120'd0, rd[23:16]}, 128'd0);

    // 0, 1, 9, 10 in order
    push_op(0); push_op(1); push_op(9); push_op(10);
    bus_write(A_START, 64'd1);
    wait_done(200);
    check("seq_model_9", exp_q[2], 128'h58980);
    check("seq_model_10", exp_q[3], 128'h375F00);
    drain_results("seq_result");
    bus_read(A_STATUS, rd);
    check("seq_overflow", {127'd0, rd[2]}, 128'd0);

    // 20! fits, 72! overflows
    push_op(20);
    bus_write(A_START, 64'd1);
    wait_done(200);
    check("fact20_model", exp_q[0], 128'h21C3677C82B40000);
    drain_results("fact20");
    push_op(72);
    bus_write(A_START, 64'd1);
    wait_done(300);
    drain_results("fact72");
    bus_read(A_STATUS, rd);
    check("fact72_overflow", {127'd0, rd[2]}, 128'd1);

    // Operand overflow and result back-pressure
    bus_write(A_CLEAR, 64'd1);
    exp_ov = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_op(i);
    bus_write(A_OPER, 64'd4);
    bus_read(A_STATUS, rd);
    check("pusherr_status", {64'd0, rd}, 128'h0408);
    bus_write(A_START, 64'd1);
    wait_done(200);
    push_op(3);
    bus_write(A_START, 64'd1);
    repeat (20) @(posedge clk);
    bus_read(A_STATUS, rd);
    check("hold_write_status", {64'd0, rd}, 128'h04000A);
    bus_read(A_RESL, rd);
    check("release_pop", {64'd0, rd}, exp_q.pop_front());
    wait_done(50);
    drain_results("backpressure");
    bus_read(A_STATUS, rd);
    check("bp_rescnt", {120'd0, rd[23:16]}, 128'd0);

    // Randomized batches
    for (int r = 0; r < 5; r++) begin
      bus_write(A_CLEAR, 64'd1);
      exp_ov = 1'b0;
      nops = $urandom_range(DEPTH, 1);
      for (int i = 0; i < nops; i++) push_op($urandom_range(40, 0));
      bus_write(A_START, 64'd1);
      wait_done(400);
      drain_results("rand_result");
      bus_read(A_STATUS, rd);
      check("rand_overflow", {127'd0, rd[2]}, {127'd0, exp_ov});
    end

    // OPCLEAR mid-MUL
    bus_write(A_CLEAR, 64'd1);
    bus_write(A_INTREN, 64'd1);
    bus_write(A_OPER, 64'd30);
    bus_write(A_OPER, 64'd7);
    bus_write(A_START, 64'd1);
    repeat (5) @(posedge clk);
    bus_write(A_CLEAR, 64'd1);
    bus_read(A_STATUS, rd);
    check("clr_status", {64'd0, rd}, 128'd0);
    bus_read(A_INTREN, rd);
    check("clr_intren", {64'd0, rd}, 128'd1);
    int_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      int_seen = int_seen | interrupt;
    end
    check("clr_no_int", {127'd0, int_seen}, 128'd0);

    // Asynchronous reset mid-MUL
    bus_write(A_OPER, 64'd30);
    bus_write(A_START, 64'd1);
    repeat (6) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_interrupt", {127'd0, interrupt}, 128'd0);
    check("arst_dout", {64'd0, s_dout}, 128'd0);
    bus_read(A_INTREN, rd);
    check("arst_intren", {64'd0, rd}, 128'd0);
    #2 reset_n = 1'b1;
    repeat (40) @(posedge clk);
    bus_read(A_STATUS, rd);
    check("arst_status", {64'd0, rd}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
